// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states,
// datapath mux selects and the control word handed from decoder to top.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRd    = 4'd3,
        StMemWb    = 4'd4,
        StMemWr    = 4'd5,
        StRtExec   = 4'd6,
        StRtWb     = 4'd7,
        StAddiExec = 4'd8,
        StAddiWb   = 4'd9,
        StBeq      = 4'd10,
        StBne      = 4'd11,
        StJump     = 4'd12,
        StTrap     = 4'd13
    } state_t;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_word_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Pure state-to-control-word decode. FETCH reports ir_write/pc_write raw;
// the top level gates them with the memory handshake.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    output ctrl_word_t ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state)
            StFetch: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
            end
            StDecode: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            StMemAdr, StAddiExec: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            StMemRd: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            StMemWb: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            StMemWr: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            StRtExec: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            StRtWb: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            StAddiWb: begin
                ctrl.reg_write = 1'b1;
            end
            StBeq, StBne: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.branch_ne     = (state == StBne);
                ctrl.pc_src        = PCSRC_ALUOUT;
            end
            StJump: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main controller: state register, next-state sequencing,
// sticky illegal-opcode flag, reset forcing and memory-ready gating.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned ALU_OP_W      = 2,
    parameter bit          MEM_HANDSHAKE = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                branch_ne,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          pc_src,
    output logic                illegal_op,
    output logic [3:0]          state_dbg
);

    state_t     state_q, state_d;
    logic       illegal_q;
    logic       ready;
    logic       fetch_gate;
    ctrl_word_t ctrl;

    assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:    if (ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OP_RTYPE:     state_d = StRtExec;
                    OP_ADDI:      state_d = StAddiExec;
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_BEQ:       state_d = StBeq;
                    OP_BNE:       state_d = StBne;
                    OP_J:         state_d = StJump;
                    default:      state_d = StTrap;
                endcase
            end
            // Only lw/sw reach here and the IR keeps the opcode stable.
            StMemAdr:   state_d = (opcode == OP_LW) ? StMemRd : StMemWr;
            StMemRd:    if (ready) state_d = StMemWb;
            StMemWr:    if (ready) state_d = StFetch;
            StRtExec:   state_d = StRtWb;
            StAddiExec: state_d = StAddiWb;
            StMemWb, StRtWb, StAddiWb, StBeq, StBne, StJump: state_d = StFetch;
            StTrap:     state_d = StTrap;
            default:    state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | (state_d == StTrap);
        end
    end

    mips_ctrl_outdec u_outdec (
        .state (state_q),
        .ctrl  (ctrl)
    );

    // IR and PC may only latch the fetched word once memory has delivered it.
    assign fetch_gate = (state_q != StFetch) | ready;

    always_comb begin
        pc_write      = rst_n & ctrl.pc_write & fetch_gate;
        ir_write      = rst_n & ctrl.ir_write & fetch_gate;
        pc_write_cond = rst_n & ctrl.pc_write_cond;
        branch_ne     = rst_n & ctrl.branch_ne;
        iord          = rst_n & ctrl.iord;
        mem_read      = rst_n & ctrl.mem_read;
        mem_write     = rst_n & ctrl.mem_write;
        mem_to_reg    = rst_n & ctrl.mem_to_reg;
        reg_dst       = rst_n & ctrl.reg_dst;
        reg_write     = rst_n & ctrl.reg_write;
        alu_src_a     = rst_n & ctrl.alu_src_a;
        alu_src_b     = rst_n ? ctrl.alu_src_b : 2'b00;
        alu_op        = rst_n ? ALU_OP_W'(ctrl.alu_op) : '0;
        pc_src        = rst_n ? ctrl.pc_src : 2'b00;
        illegal_op    = rst_n & illegal_q;
        state_dbg     = rst_n ? state_q : StFetch;
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: a directed vector table for the listed
// corner cases, then random traffic against a step-list reference model.
module tb_mips_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, mem_ready;
    logic [5:0] opcode;
    logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state_dbg;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.ALU_OP_W(2), .MEM_HANDSHAKE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    typedef struct {
        logic       rst;
        logic [5:0] opc;
        logic       rdy;
        state_t     ph;
    } vec_t;

    vec_t   vecs[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    state_t m_ph = StFetch;
    state_t m_q[$];

    // flags order: pc_write pc_write_cond branch_ne iord mem_read mem_write ir_write
    //              mem_to_reg reg_dst reg_write alu_src_a
    function automatic logic [17:0] mk(input logic [10:0] f, input logic [1:0] sb,
                                       input logic [1:0] op, input logic [1:0] ps,
                                       input logic ill);
        return {f, sb, op, ps, ill};
    endfunction

    function automatic logic [17:0] exp_word(input state_t ph, input logic rdy);
        case (ph)
            StFetch:    return mk({rdy, 3'b000, 1'b1, 1'b0, rdy, 4'b0000}, 2'b01, 2'b00, 2'b00, 1'b0);
            StDecode:   return mk(11'b000_0000_0000, 2'b11, 2'b00, 2'b00, 1'b0);
            StMemAdr:   return mk(11'b000_0000_0001, 2'b10, 2'b00, 2'b00, 1'b0);
            StMemRd:    return mk(11'b000_1100_0000, 2'b00, 2'b00, 2'b00, 1'b0);
            StMemWb:    return mk(11'b000_0000_1010, 2'b00, 2'b00, 2'b00, 1'b0);
            StMemWr:    return mk(11'b000_1010_0000, 2'b00, 2'b00, 2'b00, 1'b0);
            StRtExec:   return mk(11'b000_0000_0001, 2'b00, 2'b10, 2'b00, 1'b0);
            StRtWb:     return mk(11'b000_0000_0110, 2'b00, 2'b00, 2'b00, 1'b0);
            StAddiExec: return mk(11'b000_0000_0001, 2'b10, 2'b00, 2'b00, 1'b0);
            StAddiWb:   return mk(11'b000_0000_0010, 2'b00, 2'b00, 2'b00, 1'b0);
            StBeq:      return mk(11'b010_0000_0001, 2'b00, 2'b01, 2'b01, 1'b0);
            StBne:      return mk(11'b011_0000_0001, 2'b00, 2'b01, 2'b01, 1'b0);
            StJump:     return mk(11'b100_0000_0000, 2'b00, 2'b00, 2'b10, 1'b0);
            default:    return mk(11'b000_0000_0000, 2'b00, 2'b00, 2'b00, 1'b1);
        endcase
    endfunction

    task automatic check(input string name, input state_t ph);
        logic [21:0] exp_v, act_v;
        logic [3:0]  st;
        st    = rst_n ? ph : StFetch;
        exp_v = rst_n ? {exp_word(ph, mem_ready), st} : {18'b0, st};
        act_v = {pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
                 illegal_op, state_dbg};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act_v, exp_v);
        end
    endtask

    // Model: each instruction is a list of steps; memory steps wait on mem_ready.
    task automatic model_step();
        if (!rst_n) begin
            m_ph = StFetch;
            m_q.delete();
        end else begin
            case (m_ph)
                StFetch: if (mem_ready) m_ph = StDecode;
                StDecode: begin
                    m_q.delete();
                    case (opcode)
                        6'h23: begin m_q.push_back(StMemAdr); m_q.push_back(StMemRd);
                                     m_q.push_back(StMemWb); end
                        6'h2b: begin m_q.push_back(StMemAdr); m_q.push_back(StMemWr); end
                        6'h00: begin m_q.push_back(StRtExec); m_q.push_back(StRtWb); end
                        6'h08: begin m_q.push_back(StAddiExec); m_q.push_back(StAddiWb); end
                        6'h04: m_q.push_back(StBeq);
                        6'h05: m_q.push_back(StBne);
                        6'h02: m_q.push_back(StJump);
                        default: m_q.push_back(StTrap);
                    endcase
                    m_ph = m_q.pop_front();
                end
                StTrap: ;
                default: begin
                    if ((m_ph != StMemRd && m_ph != StMemWr) || mem_ready)
                        m_ph = (m_q.size() > 0) ? m_q.pop_front() : StFetch;
                end
            endcase
        end
    endtask

    task automatic add(input logic r, input logic [5:0] o, input logic rdy, input state_t ph);
        vec_t v;
        v.rst = r; v.opc = o; v.rdy = rdy; v.ph = ph;
        vecs.push_back(v);
    endtask

    initial begin
        logic [5:0] lw, sw, rt, addi, beq, bne, jmp, bad;
        logic [5:0] legal [7];
        lw = 6'h23; sw = 6'h2b; rt = 6'h00; addi = 6'h08;
        beq = 6'h04; bne = 6'h05; jmp = 6'h02; bad = 6'h3f;
        legal = '{6'h00, 6'h08, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02};
        rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'h00;

        add(0, lw, 1, StFetch);
        add(1, lw, 1, StFetch); add(1, lw, 1, StDecode); add(1, lw, 1, StMemAdr);
        add(1, lw, 1, StMemRd); add(1, lw, 1, StMemWb);
        add(1, sw, 1, StFetch); add(1, sw, 1, StDecode); add(1, sw, 1, StMemAdr);
        for (int i = 0; i < 3; i++) add(1, sw, 0, StMemWr);
        add(1, sw, 1, StMemWr);
        add(1, beq, 1, StFetch); add(1, beq, 1, StDecode); add(1, beq, 1, StBeq);
        add(1, bne, 1, StFetch); add(1, bne, 1, StDecode); add(1, bne, 1, StBne);
        add(1, jmp, 0, StFetch); add(1, jmp, 0, StFetch); add(1, jmp, 1, StFetch);
        add(1, jmp, 1, StDecode); add(1, jmp, 1, StJump);
        add(1, rt, 1, StFetch); add(1, rt, 1, StDecode); add(1, rt, 1, StRtExec);
        add(0, rt, 1, StRtWb);
        add(1, addi, 1, StFetch); add(1, addi, 1, StDecode); add(1, addi, 1, StAddiExec);
        add(1, addi, 1, StAddiWb);
        add(1, lw, 1, StFetch); add(1, lw, 1, StDecode); add(1, lw, 1, StMemAdr);
        add(1, lw, 0, StMemRd); add(1, lw, 1, StMemRd); add(1, lw, 1, StMemWb);
        add(1, bad, 1, StFetch); add(1, bad, 1, StDecode);
        for (int i = 0; i < 20; i++) add(1, bad, 1'(i % 2), StTrap);
        add(0, bad, 1, StFetch);
        add(1, beq, 1, StFetch); add(1, beq, 1, StDecode); add(1, beq, 1, StBeq);

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst; opcode = vecs[i].opc; mem_ready = vecs[i].rdy;
            @(negedge clk);
            check("vector", vecs[i].ph);
            @(posedge clk);
            model_step();
            #1;
            cyc++;
        end

        for (int i = 0; i < 3000; i++) begin
            rst_n = (i == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            if (m_ph == StFetch) begin
                if ($urandom_range(0, 29) == 0) opcode = 6'($urandom);
                else opcode = legal[$urandom_range(0, 6)];
            end
            @(negedge clk);
            check("random", m_ph);
            @(posedge clk);
            model_step();
            #1;
            cyc++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
